// File: rtl/mul_ctrl_if.sv
// rtl/mul_ctrl_if.sv - EX-stage M-extension request, multiplier and result bundle
interface mul_ctrl_if #(
    parameter int XLEN = 32
);
    logic                start;
    logic [2:0]          funct3;
    logic                flush;
    logic [XLEN-1:0]     op1;
    logic [XLEN-1:0]     op2;
    logic                mul_en;
    logic [XLEN-1:0]     mul_op1;
    logic [XLEN-1:0]     mul_op2;
    logic [2*XLEN-1:0]   mul_product;
    logic                stall_req;
    logic                valid;
    logic [XLEN-1:0]     result;

    modport master (
        output start, funct3, flush, op1, op2, mul_product,
        input  mul_en, mul_op1, mul_op2, stall_req, valid, result
    );

    modport slave (
        input  start, funct3, flush, op1, op2, mul_product,
        output mul_en, mul_op1, mul_op2, stall_req, valid, result
    );
endinterface

// File: rtl/mul_ctrl.sv
// rtl/mul_ctrl.sv - RV32M MUL/MULH/MULHSU/MULHU sequencer around an unsigned array multiplier
// Optional result reuse of the last completed op is enabled by MUL_RESULT_REUSE_EN.
module mul_ctrl #(
    parameter int MUL_CYCLES = 2,
    parameter int XLEN       = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    mul_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [XLEN-1:0]   ONE_X = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE_P = {{(2*XLEN-1){1'b0}}, 1'b1};

    state_t            state, state_nx;
    logic [3:0]        cnt;
    logic [2:0]        f3_q;
    logic              neg_q;
    logic              en_q;
    logic [XLEN-1:0]   op1_q, op2_q, res_q;
    logic [2*XLEN-1:0] p_q, p_fix;

    logic              accept, hit, sign1, sign2;
    logic [XLEN-1:0]   mag1, mag2, hit_res;
    logic [1:0]        code;

    assign sign1  = bus.op1[XLEN-1] & ((bus.funct3[1:0] == 2'b01) | (bus.funct3[1:0] == 2'b10));
    assign sign2  = bus.op2[XLEN-1] & (bus.funct3[1:0] == 2'b01);
    assign mag1   = sign1 ? (~bus.op1) + ONE_X : bus.op1;
    assign mag2   = sign2 ? (~bus.op2) + ONE_X : bus.op2;
    assign code   = (bus.funct3[1:0] == 2'b01) ? 2'd1 :
                    (bus.funct3[1:0] == 2'b10) ? 2'd2 : 2'd0;
    assign p_fix  = neg_q ? (~p_q) + ONE_P : p_q;
    assign accept = (state == IDLE) & bus.start & ~bus.funct3[2] & ~bus.flush;

`ifdef MUL_RESULT_REUSE_EN
    logic              c_valid;
    logic [XLEN-1:0]   c_op1, c_op2;
    logic [1:0]        c_code;
    logic [2*XLEN-1:0] c_p;

    // A new MUL only needs the low half, which is identical for every signedness.
    assign hit     = c_valid & (bus.op1 == c_op1) & (bus.op2 == c_op2) &
                     ((code == c_code) | (bus.funct3[1:0] == 2'b00));
    assign hit_res = (bus.funct3[1:0] == 2'b00) ? c_p[XLEN-1:0] : c_p[2*XLEN-1:XLEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_valid <= 1'b0;
            c_op1   <= '0;
            c_op2   <= '0;
            c_code  <= 2'd0;
            c_p     <= '0;
        end else if (bus.flush) begin
            c_valid <= 1'b0;
        end else if (accept && !hit) begin
            c_valid <= 1'b0;
            c_op1   <= bus.op1;
            c_op2   <= bus.op2;
            c_code  <= code;
        end else if (state == FIX) begin
            c_valid <= 1'b1;
            c_p     <= p_fix;
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_res = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = hit ? DONE : CALC;
            CALC: if (cnt == 4'd0) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (bus.flush) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 4'd0;
            f3_q  <= 3'd0;
            neg_q <= 1'b0;
            en_q  <= 1'b0;
            op1_q <= '0;
            op2_q <= '0;
            res_q <= '0;
            p_q   <= '0;
        end else if (bus.flush) begin
            en_q <= 1'b0;
            cnt  <= 4'd0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    f3_q  <= bus.funct3;
                    neg_q <= sign1 ^ sign2;
                    if (hit) begin
                        res_q <= hit_res;
                    end else begin
                        op1_q <= mag1;
                        op2_q <= mag2;
                        en_q  <= 1'b1;
                        cnt   <= 4'(MUL_CYCLES - 1);
                    end
                end
                CALC: begin
                    if (cnt == 4'd0) p_q <= bus.mul_product;
                    else             cnt <= cnt - 4'd1;
                end
                FIX: begin
                    p_q   <= p_fix;
                    en_q  <= 1'b0;
                    res_q <= (f3_q[1:0] == 2'b00) ? p_fix[XLEN-1:0] : p_fix[2*XLEN-1:XLEN];
                end
                default: ;
            endcase
        end
    end

    // stall drops in DONE so the pipeline advances on the valid cycle.
    assign bus.stall_req = rst_n & ~bus.flush &
                           (((state == IDLE) & bus.start & ~bus.funct3[2]) |
                            (state == CALC) | (state == FIX));
    assign bus.valid     = (state == DONE) & ~bus.flush;
    assign bus.mul_en    = en_q;
    assign bus.mul_op1   = op1_q;
    assign bus.mul_op2   = op2_q;
    assign bus.result    = res_q;
endmodule

// File: tb/tb_mul_ctrl.sv
// tb/tb_mul_ctrl.sv - scoreboard bench for mul_ctrl with directed RV32M vectors
module tb_mul_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_ctrl_if #(.XLEN(32)) bus ();

    // Behavioural stand-in for the external unsigned array multiplier.
    assign bus.mul_product = {32'b0, bus.mul_op1} * {32'b0, bus.mul_op2};

    mul_ctrl #(.MUL_CYCLES(2), .XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam int LAT = 4;
`ifdef MUL_RESULT_REUSE_EN
    localparam int LAT_HIT = 1;
`else
    localparam int LAT_HIT = 4;
`endif

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_valid  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.valid === 1'b1) begin
            n_valid++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got result %h expected no valid", bus.result);
            end else begin
                e = sb.pop_front();
                check("result", 64'(bus.result), 64'(e.res));
                check("latency_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op1    = a;
        bus.op2    = b;
    endtask

    task automatic wait_valid();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.valid === 1'b1) seen = 1'b1;
        end
        check("valid_seen", 64'(seen), 64'd1);
    endtask

    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat);
        issue(f3, a, b);
        sb.push_back('{res, cyc + lat});
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_valid();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int vbefore;
        bus.start  = 1'b0;
        bus.funct3 = 3'd0;
        bus.flush  = 1'b0;
        bus.op1    = '0;
        bus.op2    = '0;

        repeat (3) @(negedge clk);
        check("rst_mul_en", 64'(bus.mul_en), 64'd0);
        check("rst_valid", 64'(bus.valid), 64'd0);
        check("rst_stall", 64'(bus.stall_req), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_mul_op1", 64'(bus.mul_op1), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // MUL 7 * -3 with stall profile over the full latency
        issue(3'b000, 32'd7, 32'hFFFF_FFFD);
        sb.push_back('{32'hFFFF_FFEB, cyc + LAT});
        @(negedge clk);
        check("stall_c0", 64'(bus.stall_req), 64'd1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("stall_busy", 64'(bus.stall_req), 64'd1);
        end
        @(negedge clk);
        check("stall_c4", 64'(bus.stall_req), 64'd0);
        check("valid_c4", 64'(bus.valid), 64'd1);

        // MULH of the most negative value with itself
        issue(3'b001, 32'h8000_0000, 32'h8000_0000);
        sb.push_back('{32'h4000_0000, cyc + LAT});
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("mulh_mul_op1", 64'(bus.mul_op1), 64'h8000_0000);
        check("mulh_mul_op2", 64'(bus.mul_op2), 64'h8000_0000);
        check("mulh_mul_en", 64'(bus.mul_en), 64'd1);
        wait_valid();

        // MULHSU -1 * 0xFFFFFFFF: magnitude 1 for the signed side only
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        sb.push_back('{32'hFFFF_FFFF, cyc + LAT});
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("mulhsu_mul_op1", 64'(bus.mul_op1), 64'd1);
        check("mulhsu_mul_op2", 64'(bus.mul_op2), 64'hFFFF_FFFF);
        wait_valid();

        // MULHU then MUL on the same operands, back to back
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT);
        do_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, LAT_HIT);

        // MULH killed by flush in the second CALC cycle
        issue(3'b001, 32'd5, 32'd6);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush_stall_same", 64'(bus.stall_req), 64'd0);
        check("flush_valid", 64'(bus.valid), 64'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_stall_next", 64'(bus.stall_req), 64'd0);
        check("flush_mul_en", 64'(bus.mul_en), 64'd0);
        vbefore = n_valid;
        issue(3'b100, 32'd1, 32'd2);
        @(negedge clk);
        check("nonm_stall", 64'(bus.stall_req), 64'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        check("no_valid_after_flush", 64'(n_valid), 64'(vbefore));

        // Asynchronous reset in the middle of CALC
        issue(3'b000, 32'd9, 32'd9);
        @(posedge clk); #1;
        bus.start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mul_en", 64'(bus.mul_en), 64'd0);
        check("arst_stall", 64'(bus.stall_req), 64'd0);
        check("arst_valid", 64'(bus.valid), 64'd0);
        check("arst_result", 64'(bus.result), 64'd0);
        check("arst_mul_op1", 64'(bus.mul_op1), 64'd0);
        check("arst_mul_op2", 64'(bus.mul_op2), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op(3'b000, 32'd3, 32'd5, 32'h0000_000F, LAT);

        repeat (5) @(posedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
